// File: rtl/ysyx_22050019_lsu_pkg.sv
// Shared encodings for the LSU AXI master: access sizes, FSM states, AXI response codes.
package ysyx_22050019_lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW   = 3'd3,
      ST_W    = 3'd4,
      ST_B    = 3'd5,
      ST_RSP  = 3'd6
   } lsu_state_e;

   function automatic logic [3:0] size_to_nbytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/ysyx_22050019_lsu_lane_align.sv
// Combinational lane steering: store data/strobes onto the 64-bit bus, load data back to LSB with extension.
module ysyx_22050019_lsu_lane_align
   import ysyx_22050019_lsu_pkg::*;
(
   input  logic [2:0]  off,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [63:0] wdata,
   input  logic [63:0] rdata,
   output logic [63:0] w_data,
   output logic [7:0]  w_strb,
   output logic [63:0] ext_rdata
);

   logic [5:0]  sh_amt;
   logic [7:0]  strb_base;
   logic [63:0] rsh;

   always_comb begin
      sh_amt = {off, 3'b000};
      w_data = wdata << sh_amt;
      case (size)
         SZ_B:    strb_base = 8'h01;
         SZ_H:    strb_base = 8'h03;
         SZ_W:    strb_base = 8'h0F;
         default: strb_base = 8'hFF;
      endcase
      // Strobes past lane 7 fall off the top; callers never issue such accesses.
      w_strb = strb_base << off;
      rsh    = rdata >> sh_amt;
      case (size)
         SZ_B:    ext_rdata = {{56{sext & rsh[7]}},  rsh[7:0]};
         SZ_H:    ext_rdata = {{48{sext & rsh[15]}}, rsh[15:0]};
         SZ_W:    ext_rdata = {{32{sext & rsh[31]}}, rsh[31:0]};
         default: ext_rdata = rsh;
      endcase
   end

endmodule

// File: rtl/ysyx_22050019_lsu_axi_master.sv
// LSU-side AXI master: one load or store at a time, AR/R or AW/W/B, then a single-cycle response pulse.
module ysyx_22050019_lsu_axi_master
   import ysyx_22050019_lsu_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ADDR_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic                      req_wen_i,
   input  logic [AXI_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [1:0]                req_size_i,
   input  logic                      req_sext_i,
   input  logic [AXI_DATA_WIDTH-1:0] req_wdata_i,
   output logic                      rsp_valid_o,
   output logic [AXI_DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      axi_aw_valid_o,
   input  logic                      axi_aw_ready_i,
   output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr_o,
   output logic                      axi_w_valid_o,
   input  logic                      axi_w_ready_i,
   output logic [AXI_DATA_WIDTH-1:0] axi_w_data_o,
   output logic [7:0]                axi_w_strb_o,
   input  logic                      axi_b_valid_i,
   output logic                      axi_b_ready_o,
   input  logic [1:0]                axi_b_resp_i,
   output logic                      axi_ar_valid_o,
   input  logic                      axi_ar_ready_i,
   output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_o,
   input  logic                      axi_r_valid_i,
   output logic                      axi_r_ready_o,
   input  logic [1:0]                axi_r_resp_i,
   input  logic [AXI_DATA_WIDTH-1:0] axi_r_data_i
);

   // Handshake rule on every channel (request, AW, W, B, AR, R): a transfer happens on the
   // rising edge where valid and ready are both high; a raised valid and its payload hold
   // unchanged until that edge. The response pulse has no ready and cannot be stalled.

   lsu_state_e                state;
   logic [2:0]                off_q;
   logic [1:0]                size_q;
   logic                      sext_q;
   logic [AXI_DATA_WIDTH-1:0] wdata_q;
   logic                      req_mis;
   logic [63:0]               lane_w_data;
   logic [7:0]                lane_w_strb;
   logic [63:0]               lane_ext_rdata;

   always_comb begin
      req_mis = ({1'b0, req_addr_i[2:0]} + size_to_nbytes(req_size_i)) > 4'd8;
   end

   ysyx_22050019_lsu_lane_align u_lane (
      .off       (off_q),
      .size      (size_q),
      .sext      (sext_q),
      .wdata     (wdata_q),
      .rdata     (axi_r_data_i),
      .w_data    (lane_w_data),
      .w_strb    (lane_w_strb),
      .ext_rdata (lane_ext_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         off_q          <= '0;
         size_q         <= '0;
         sext_q         <= 1'b0;
         wdata_q        <= '0;
         req_ready_o    <= 1'b1;
         rsp_valid_o    <= 1'b0;
         rsp_rdata_o    <= '0;
         rsp_err_o      <= 1'b0;
         axi_aw_valid_o <= 1'b0;
         axi_aw_addr_o  <= '0;
         axi_w_valid_o  <= 1'b0;
         axi_w_data_o   <= '0;
         axi_w_strb_o   <= '0;
         axi_b_ready_o  <= 1'b0;
         axi_ar_valid_o <= 1'b0;
         axi_ar_addr_o  <= '0;
         axi_r_ready_o  <= 1'b0;
      end else begin
         rsp_valid_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  off_q       <= req_addr_i[2:0];
                  size_q      <= req_size_i;
                  sext_q      <= req_sext_i;
                  wdata_q     <= req_wdata_i;
                  req_ready_o <= 1'b0;
                  if (req_mis) begin
                     // Line-crossing access: report an error without touching the bus.
                     state       <= ST_RSP;
                     rsp_valid_o <= 1'b1;
                     rsp_err_o   <= 1'b1;
                     rsp_rdata_o <= '0;
                  end else if (req_wen_i) begin
                     state          <= ST_AW;
                     axi_aw_valid_o <= 1'b1;
                     axi_aw_addr_o  <= req_addr_i;
                  end else begin
                     state          <= ST_AR;
                     axi_ar_valid_o <= 1'b1;
                     axi_ar_addr_o  <= req_addr_i;
                  end
               end
            end
            ST_AR: begin
               if (axi_ar_ready_i) begin
                  state          <= ST_R;
                  axi_ar_valid_o <= 1'b0;
                  axi_r_ready_o  <= 1'b1;
               end
            end
            ST_R: begin
               if (axi_r_valid_i) begin
                  state         <= ST_RSP;
                  axi_r_ready_o <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  rsp_err_o     <= (axi_r_resp_i != AXI_RESP_OKAY);
                  rsp_rdata_o   <= (axi_r_resp_i != AXI_RESP_OKAY) ? '0 : lane_ext_rdata;
               end
            end
            ST_AW: begin
               if (axi_aw_ready_i) begin
                  state          <= ST_W;
                  axi_aw_valid_o <= 1'b0;
                  axi_w_valid_o  <= 1'b1;
                  axi_w_data_o   <= lane_w_data;
                  axi_w_strb_o   <= lane_w_strb;
               end
            end
            ST_W: begin
               if (axi_w_ready_i) begin
                  state         <= ST_B;
                  axi_w_valid_o <= 1'b0;
                  axi_b_ready_o <= 1'b1;
               end
            end
            ST_B: begin
               if (axi_b_valid_i) begin
                  state         <= ST_RSP;
                  axi_b_ready_o <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  rsp_err_o     <= (axi_b_resp_i != AXI_RESP_OKAY);
                  rsp_rdata_o   <= '0;
               end
            end
            ST_RSP: begin
               state       <= ST_IDLE;
               req_ready_o <= 1'b1;
               rsp_err_o   <= 1'b0;
               rsp_rdata_o <= '0;
            end
            default: begin
               state       <= ST_IDLE;
               req_ready_o <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22050019_lsu_axi_master.sv
// Bench for the LSU AXI master: directed vector table, reset-in-W sequence, randomized loads/stores vs a reference model.
module tb_ysyx_22050019_lsu_axi_master;

   typedef struct {
      bit          wen;
      logic [63:0] addr;
      logic [1:0]  size;
      bit          sext;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic [1:0]  resp;
      int          a_dly;
      int          d_dly;
      bit          mis;
      bit          exp_err;
      logic [63:0] exp_rdata;
      logic [63:0] exp_wdata;
      logic [7:0]  exp_strb;
   } vec_t;

   typedef struct {
      int          rsp_cnt;
      int          rsp_cyc;
      logic [63:0] rdata;
      logic        err;
      bit          saw_ar;
      bit          saw_aw;
      logic [63:0] ar_addr;
      logic [63:0] aw_addr;
      logic [63:0] w_data;
      logic [7:0]  w_strb;
      int          ar_cyc;
      int          aw_cyc;
      bit          unstable;
      bit          ready_leak;
      bit          timeout;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_wen_i = 1'b0;
   logic [63:0] req_addr_i = '0;
   logic [1:0]  req_size_i = '0;
   logic        req_sext_i = 1'b0;
   logic [63:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic [63:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        axi_aw_valid_o;
   logic        axi_aw_ready_i = 1'b0;
   logic [63:0] axi_aw_addr_o;
   logic        axi_w_valid_o;
   logic        axi_w_ready_i = 1'b0;
   logic [63:0] axi_w_data_o;
   logic [7:0]  axi_w_strb_o;
   logic        axi_b_valid_i = 1'b0;
   logic        axi_b_ready_o;
   logic [1:0]  axi_b_resp_i = '0;
   logic        axi_ar_valid_o;
   logic        axi_ar_ready_i = 1'b0;
   logic [63:0] axi_ar_addr_o;
   logic        axi_r_valid_i = 1'b0;
   logic        axi_r_ready_o;
   logic [1:0]  axi_r_resp_i = '0;
   logic [63:0] axi_r_data_i = '0;

   int n_vec  = 0;
   int n_miss = 0;

   ysyx_22050019_lsu_axi_master dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_wen_i      (req_wen_i),
      .req_addr_i     (req_addr_i),
      .req_size_i     (req_size_i),
      .req_sext_i     (req_sext_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_err_o      (rsp_err_o),
      .axi_aw_valid_o (axi_aw_valid_o),
      .axi_aw_ready_i (axi_aw_ready_i),
      .axi_aw_addr_o  (axi_aw_addr_o),
      .axi_w_valid_o  (axi_w_valid_o),
      .axi_w_ready_i  (axi_w_ready_i),
      .axi_w_data_o   (axi_w_data_o),
      .axi_w_strb_o   (axi_w_strb_o),
      .axi_b_valid_i  (axi_b_valid_i),
      .axi_b_ready_o  (axi_b_ready_o),
      .axi_b_resp_i   (axi_b_resp_i),
      .axi_ar_valid_o (axi_ar_valid_o),
      .axi_ar_ready_i (axi_ar_ready_i),
      .axi_ar_addr_o  (axi_ar_addr_o),
      .axi_r_valid_i  (axi_r_valid_i),
      .axi_r_ready_o  (axi_r_ready_o),
      .axi_r_resp_i   (axi_r_resp_i),
      .axi_r_data_i   (axi_r_data_i)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s.%s: got %h expected %h", tag, what, act, exp);
      end
   endtask

   // Reference model: expected outcome from the size/offset rules using plain arithmetic.
   function automatic vec_t model(input vec_t v);
      vec_t        r;
      int          nb;
      int          off;
      logic [63:0] sh;
      logic [63:0] mask;
      logic [63:0] val;
      logic [15:0] sw;
      r   = v;
      nb  = 1 << v.size;
      off = int'(v.addr[2:0]);
      r.mis       = (off + nb) > 8;
      r.exp_wdata = v.wdata << (8 * off);
      sw          = ((16'd1 << nb) - 16'd1) << off;
      r.exp_strb  = sw[7:0];
      r.exp_err   = r.mis || (v.resp != 2'b00);
      if (v.wen || r.exp_err) begin
         r.exp_rdata = '0;
      end else begin
         sh   = v.rdata >> (8 * off);
         mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
         val  = sh & mask;
         if (v.sext && val[8 * nb - 1]) val = val | ~mask;
         r.exp_rdata = val;
      end
      return r;
   endfunction

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      axi_aw_ready_i = 1'b0; axi_w_ready_i = 1'b0; axi_b_valid_i = 1'b0;
      axi_ar_ready_i = 1'b0; axi_r_valid_i = 1'b0; req_valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Driver plus responsive slave: issues one request and observes everything until IDLE returns.
   task automatic do_txn(input vec_t v, output obs_t o);
      int ar_n, r_n, aw_n, w_n, b_n;
      bit done;
      o = '{default: 0};
      ar_n = 0; r_n = 0; aw_n = 0; w_n = 0; b_n = 0; done = 0;
      @(negedge clk);
      req_valid_i  = 1'b1;
      req_wen_i    = v.wen;
      req_addr_i   = v.addr;
      req_size_i   = v.size;
      req_sext_i   = v.sext;
      req_wdata_i  = v.wdata;
      axi_r_data_i = v.rdata;
      axi_r_resp_i = v.wen ? 2'b00 : v.resp;
      axi_b_resp_i = v.wen ? v.resp : 2'b00;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         @(negedge clk);
         if (cyc == 0) req_valid_i = 1'b0;
         if (req_ready_o && (o.rsp_cnt == 0 || rsp_valid_o)) o.ready_leak = 1;
         if (rsp_valid_o) begin
            o.rsp_cnt++;
            o.rsp_cyc = cyc;
            o.rdata   = rsp_rdata_o;
            o.err     = rsp_err_o;
         end
         if (axi_ar_valid_o) begin
            if (!o.saw_ar) o.ar_addr = axi_ar_addr_o;
            else if (axi_ar_addr_o !== o.ar_addr) o.unstable = 1;
            o.saw_ar = 1; o.ar_cyc++;
            axi_ar_ready_i = (ar_n >= v.a_dly); ar_n++;
         end else axi_ar_ready_i = 1'b0;
         if (axi_r_ready_o) begin
            axi_r_valid_i = (r_n >= v.d_dly); r_n++;
         end else axi_r_valid_i = 1'b0;
         if (axi_aw_valid_o) begin
            if (!o.saw_aw) o.aw_addr = axi_aw_addr_o;
            else if (axi_aw_addr_o !== o.aw_addr) o.unstable = 1;
            o.saw_aw = 1; o.aw_cyc++;
            axi_aw_ready_i = (aw_n >= v.a_dly); aw_n++;
         end else axi_aw_ready_i = 1'b0;
         if (axi_w_valid_o) begin
            if (w_n == 0) begin
               o.w_data = axi_w_data_o;
               o.w_strb = axi_w_strb_o;
            end else if (axi_w_data_o !== o.w_data || axi_w_strb_o !== o.w_strb) o.unstable = 1;
            axi_w_ready_i = (w_n >= v.d_dly); w_n++;
         end else axi_w_ready_i = 1'b0;
         if (axi_b_ready_o) begin
            axi_b_valid_i = (b_n >= v.d_dly); b_n++;
         end else axi_b_valid_i = 1'b0;
         if (o.rsp_cnt > 0 && req_ready_o && !rsp_valid_o) done = 1;
      end
      axi_aw_ready_i = 1'b0; axi_w_ready_i = 1'b0; axi_b_valid_i = 1'b0;
      axi_ar_ready_i = 1'b0; axi_r_valid_i = 1'b0;
      if (!done) begin
         o.timeout = 1;
         pulse_reset();
      end else begin
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (rsp_valid_o) o.rsp_cnt++;
         end
      end
   endtask

   task automatic check_txn(input string tag, input vec_t v, input obs_t o);
      bit traffic;
      traffic = !v.mis;
      chk(tag, "timeout", o.timeout, 0);
      chk(tag, "rsp_cnt", o.rsp_cnt, 1);
      chk(tag, "rsp_err", o.err, v.exp_err);
      chk(tag, "rsp_rdata", o.rdata, v.exp_rdata);
      chk(tag, "ar_seen", o.saw_ar, !v.wen && traffic);
      chk(tag, "aw_seen", o.saw_aw, v.wen && traffic);
      chk(tag, "stable", o.unstable, 0);
      chk(tag, "req_ready_busy", o.ready_leak, 0);
      if (!v.wen && traffic) begin
         chk(tag, "ar_addr", o.ar_addr, v.addr);
         chk(tag, "ar_cycles", o.ar_cyc, 64'(v.a_dly + 1));
      end
      if (v.wen && traffic) begin
         chk(tag, "aw_addr", o.aw_addr, v.addr);
         chk(tag, "aw_cycles", o.aw_cyc, 64'(v.a_dly + 1));
         chk(tag, "w_data", o.w_data, v.exp_wdata);
         chk(tag, "w_strb", o.w_strb, v.exp_strb);
      end
      if (v.mis) chk(tag, "err_latency", o.rsp_cyc, 0);
   endtask

   initial begin
      vec_t tbl[11];
      vec_t v;
      obs_t o;
      bit   got_w;
      int   pulses;

      //           wen addr           sz   sx wdata                  rdata                  resp  ad dd mis err exp_rdata              exp_wdata              strb
      tbl[0]  = '{1, 64'h80000003, 2'd0, 0, 64'h00000000000000AB, 64'h0,                 2'b00, 0, 0, 0, 1'b0, 64'h0,                 64'h00000000AB000000, 8'h08};
      tbl[1]  = '{0, 64'h80000004, 2'd2, 1, 64'h0,                 64'h8000000012345678, 2'b00, 0, 0, 0, 1'b0, 64'hFFFFFFFF80000000, 64'h0,                 8'h00};
      tbl[2]  = '{0, 64'h80000004, 2'd2, 0, 64'h0,                 64'h8000000012345678, 2'b00, 0, 0, 0, 1'b0, 64'h0000000080000000, 64'h0,                 8'h00};
      tbl[3]  = '{0, 64'h80000007, 2'd1, 1, 64'h0,                 64'h1111111111111111, 2'b00, 0, 0, 1, 1'b1, 64'h0,                 64'h0,                 8'h00};
      tbl[4]  = '{0, 64'h80000008, 2'd3, 0, 64'h0,                 64'h0123456789ABCDEF, 2'b00, 5, 3, 0, 1'b0, 64'h0123456789ABCDEF, 64'h0,                 8'h00};
      tbl[5]  = '{1, 64'h80000010, 2'd3, 0, 64'h1122334455667788, 64'h0,                 2'b10, 0, 0, 0, 1'b1, 64'h0,                 64'h1122334455667788, 8'hFF};
      tbl[6]  = '{0, 64'h80000025, 2'd0, 1, 64'h0,                 64'h0000800000000000, 2'b00, 1, 2, 0, 1'b0, 64'hFFFFFFFFFFFFFF80, 64'h0,                 8'h00};
      tbl[7]  = '{1, 64'h80000036, 2'd1, 0, 64'h000000000000BEEF, 64'h0,                 2'b00, 2, 1, 0, 1'b0, 64'h0,                 64'hBEEF000000000000, 8'hC0};
      tbl[8]  = '{0, 64'h80000042, 2'd2, 1, 64'h0,                 64'h0000DEADBEEF0000, 2'b00, 0, 0, 0, 1'b0, 64'hFFFFFFFFDEADBEEF, 64'h0,                 8'h00};
      tbl[9]  = '{1, 64'h80000045, 2'd2, 0, 64'h00000000CAFEBABE, 64'h0,                 2'b00, 0, 0, 1, 1'b1, 64'h0,                 64'h0,                 8'h00};
      tbl[10] = '{0, 64'h80000001, 2'd3, 0, 64'h0,                 64'hFFFFFFFFFFFFFFFF, 2'b00, 0, 0, 1, 1'b1, 64'h0,                 64'h0,                 8'h00};

      // reset state
      repeat (3) @(negedge clk);
      chk("reset", "req_ready", req_ready_o, 1);
      chk("reset", "valids", {rsp_valid_o, rsp_err_o, axi_aw_valid_o, axi_w_valid_o,
                              axi_b_ready_o, axi_ar_valid_o, axi_r_ready_o}, 0);
      chk("reset", "rsp_rdata", rsp_rdata_o, 0);
      chk("reset", "addrs", axi_aw_addr_o | axi_ar_addr_o, 0);
      chk("reset", "w_data_strb", axi_w_data_o | {56'h0, axi_w_strb_o}, 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         do_txn(tbl[i], o);
         check_txn($sformatf("tbl%0d", i), tbl[i], o);
      end

      // reset while the W channel is waiting
      @(negedge clk);
      req_valid_i = 1'b1; req_wen_i = 1'b1; req_addr_i = 64'h80000020;
      req_size_i = 2'd3; req_wdata_i = 64'h5555AAAA5555AAAA;
      axi_aw_ready_i = 1'b1; axi_w_ready_i = 1'b0;
      got_w = 0;
      for (int i = 0; i < 20 && !got_w; i++) begin
         @(negedge clk);
         req_valid_i = 1'b0;
         if (axi_w_valid_o) got_w = 1;
      end
      chk("rst_mid", "reached_w", got_w, 1);
      rst = 1'b1; axi_aw_ready_i = 1'b0;
      @(negedge clk);
      chk("rst_mid", "valids", {rsp_valid_o, axi_aw_valid_o, axi_w_valid_o,
                                axi_b_ready_o, axi_ar_valid_o, axi_r_ready_o}, 0);
      chk("rst_mid", "req_ready", req_ready_o, 1);
      rst = 1'b0;
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid_o) pulses++;
      end
      chk("rst_mid", "no_rsp", pulses, 0);
      v = '{default: 0};
      v.addr = 64'h80000100; v.size = 2'd3; v.rdata = 64'hCAFEF00D12345678;
      v = model(v);
      do_txn(v, o);
      check_txn("after_rst_ld", v, o);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         v = '{default: 0};
         v.wen   = 1'($urandom_range(0, 1));
         v.size  = 2'($urandom_range(0, 3));
         v.addr  = 64'h80000000 + 64'($urandom_range(0, 255) * 8) + 64'($urandom_range(0, 7));
         v.sext  = 1'($urandom_range(0, 1));
         v.wdata = {$urandom, $urandom};
         v.rdata = {$urandom, $urandom};
         v.resp  = (v.wen && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         v.a_dly = $urandom_range(0, 3);
         v.d_dly = $urandom_range(0, 3);
         v = model(v);
         do_txn(v, o);
         check_txn($sformatf("rnd%0d", i), v, o);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
